rle_prefetch_buffer: RTL and testbench

Prefetch stage between spi_flash_controller and the RLE video decoder. It keeps the SPI flash streaming ahead of the decoder, so decoder reads never stall on SPI latency during active video. It owns the flash word address and buffers 16-bit words in a small FIFO. The decoder pops words with a valid/pop handshake and can restart the stream at a new word address, for example at frame start or for line repeat.

---
 rtl/rle_prefetch_buffer_pkg.sv | 23 ++
 rtl/rle_prefetch_buffer_if.sv | 36 +++
 rtl/rle_prefetch_buffer_word_fifo.sv | 62 ++++++
 rtl/rle_prefetch_buffer.sv | 137 +++++++++++++
 tb/tb_rle_prefetch_buffer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rle_prefetch_buffer_pkg.sv
// Shared definitions for the RLE prefetch buffer.
//   state_t        : prefetch FSM states
//   DEFAULT_DEPTH  : default FIFO depth in 16-bit words
//   DEFAULT_ADDR_BITS : default flash byte-address width
//   level_w()      : width of a 0..depth occupancy count
package rle_prefetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STOPPING,
    STARTING,
    FETCH,
    FULL
  } state_t;

  localparam int DEFAULT_DEPTH     = 4;
  localparam int DEFAULT_ADDR_BITS = 24;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rle_prefetch_buffer_if.sv
// Request/response bus between the prefetch buffer and spi_flash_controller.
//   spi_start_read    : open a read at spi_addr (one-cycle pulse)
//   spi_continue_read : fetch the next sequential word (one-cycle pulse)
//   spi_stop_read     : end the current read (one-cycle pulse)
//   spi_addr          : flash byte address
//   spi_data          : word returned by the controller
//   spi_busy          : controller busy, rises the cycle after any request
// master = prefetch buffer, slave = flash controller.
interface rle_prefetch_buffer_if #(
  parameter int ADDR_BITS = 24
);
  logic                 spi_start_read;
  logic                 spi_continue_read;
  logic                 spi_stop_read;
  logic [ADDR_BITS-1:0] spi_addr;
  logic [15:0]          spi_data;
  logic                 spi_busy;

  modport master (
    output spi_start_read,
    output spi_continue_read,
    output spi_stop_read,
    output spi_addr,
    input  spi_data,
    input  spi_busy
  );

  modport slave (
    input  spi_start_read,
    input  spi_continue_read,
    input  spi_stop_read,
    input  spi_addr,
    output spi_data,
    output spi_busy
  );
endinterface

// File: rtl/rle_prefetch_buffer_word_fifo.sv
// Synchronous DEPTH x 16 word FIFO.
//   clk, rstn  : clock, asynchronous active-low reset (pointers/count only)
//   push       : write push_data (dropped when full unless popping this cycle)
//   pop        : consume head (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   head/valid : head word (0 when empty) and non-empty flag
//   level      : occupancy 0..DEPTH
module word_fifo
  import rle_prefetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push,
  input  logic [15:0]               push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [15:0]               head,
  output logic                      valid,
  output logic [level_w(DEPTH)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] count;
  logic          pop_eff;
  logic          push_eff;

  assign pop_eff  = pop && (count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_eff = push && ((count != LW'(DEPTH)) || pop_eff);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + PW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + LW'(push_eff) - LW'(pop_eff);
    end
  end

  // Storage carries data only; emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;
  assign level = count;

endmodule

// File: rtl/rle_prefetch_buffer.sv
// Prefetch stage between spi_flash_controller and the RLE video decoder.
// Keeps a flash read session streaming ahead of the decoder into a small
// word FIFO and owns the flash word address.
//   clk, rstn            : clock, asynchronous active-low reset
//   restart/restart_addr : flush and restart streaming at a word address
//   halt                 : flush, close the session, go idle
//   spi                  : request bus to the flash controller (master side)
//   data_out/data_valid  : FIFO head word and non-empty flag
//   data_pop             : consume head word (ignored when not valid)
//   level                : FIFO occupancy
module rle_prefetch_buffer
  import rle_prefetch_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      restart,
  input  logic [ADDR_BITS-2:0]      restart_addr,
  input  logic                      halt,
  rle_prefetch_buffer_if.master     spi,
  output logic [15:0]               data_out,
  output logic                      data_valid,
  input  logic                      data_pop,
  output logic [level_w(DEPTH)-1:0] level
);
  localparam int LW  = level_w(DEPTH);
  localparam int WAW = ADDR_BITS - 1;

  state_t         state;
  state_t         state_next;
  logic [WAW-1:0] word_addr;
  logic           req_last;
  logic           start_read;
  logic           continue_read;
  logic           stop_read;
  logic           push;
  logic           flush;
  logic           pop_ok;
  logic           word_ready;
  logic           has_room;
  logic           session_open;

  assign pop_ok       = data_pop && data_valid;
  // The controller raises busy only the cycle after a request, so a low busy
  // right after our own request does not yet mean the word is there.
  assign word_ready   = !spi.spi_busy && !req_last;
  assign has_room     = (level != LW'(DEPTH)) || pop_ok;
  assign session_open = (state == FETCH) || (state == FULL);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; restart outranks halt, both outrank normal flow.
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = (state == IDLE) ? STARTING : STOPPING;
    end else if (halt) begin
      state_next = IDLE;
    end else begin
      case (state)
        STOPPING: if (!spi.spi_busy) state_next = STARTING;
        STARTING: state_next = FETCH;
        FETCH:    if (word_ready && !has_room) state_next = FULL;
        FULL:     if (pop_ok) state_next = FETCH;
        default:  ;
      endcase
    end
  end

  // Output logic: SPI pulses and FIFO/address actions
  always_comb begin
    start_read    = 1'b0;
    continue_read = 1'b0;
    stop_read     = 1'b0;
    push          = 1'b0;
    flush         = restart || halt;
    if (restart || halt) begin
      // STOPPING already issued its stop; STARTING has not opened anything.
      stop_read = session_open;
    end else begin
      case (state)
        STARTING: start_read = 1'b1;
        FETCH: begin
          if (word_ready && has_room) begin
            push          = 1'b1;
            continue_read = 1'b1;
          end
        end
        FULL: begin
          if (pop_ok) begin
            push          = 1'b1;
            continue_read = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Word address always names the next word to be pushed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_addr <= '0;
      req_last  <= 1'b0;
    end else begin
      req_last <= start_read || continue_read || stop_read;
      if (restart)   word_addr <= restart_addr;
      else if (push) word_addr <= word_addr + WAW'(1);
    end
  end

  assign spi.spi_start_read    = start_read;
  assign spi.spi_continue_read = continue_read;
  assign spi.spi_stop_read     = stop_read;
  assign spi.spi_addr          = {word_addr, 1'b0};

  word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (spi.spi_data),
    .pop       (pop_ok),
    .flush     (flush),
    .head      (data_out),
    .valid     (data_valid),
    .level     (level)
  );

endmodule

// File: tb/tb_rle_prefetch_buffer.sv
// Testbench for rle_prefetch_buffer: a latency-configurable flash controller
// model answers SPI requests with word_of(address); the decoder side is
// checked against the expected word-address stream after each restart.
module tb_rle_prefetch_buffer;
  import rle_prefetch_pkg::*;

  localparam int DEPTH     = 4;
  localparam int ADDR_BITS = 24;
  localparam int LW        = level_w(DEPTH);

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 restart = 1'b0;
  logic                 halt = 1'b0;
  logic                 data_pop = 1'b0;
  logic [ADDR_BITS-2:0] restart_addr = '0;
  logic [15:0]          data_out;
  logic                 data_valid;
  logic [LW-1:0]        level;

  rle_prefetch_buffer_if #(.ADDR_BITS(ADDR_BITS)) spi_bus ();

  rle_prefetch_buffer #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .restart      (restart),
    .restart_addr (restart_addr),
    .halt         (halt),
    .spi          (spi_bus),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_pop     (data_pop),
    .level        (level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] word_of(input logic [22:0] a);
    return a[15:0] ^ 16'hA011;
  endfunction

  // Flash controller model: busy for lat cycles after start/continue,
  // two cycles after stop; it tracks its own sequential address.
  int          lat = 3;
  int          cnt = 0;
  logic [22:0] caddr = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_bus.spi_busy <= 1'b0;
      spi_bus.spi_data <= '0;
      cnt              <= 0;
      caddr            <= '0;
    end else if (spi_bus.spi_start_read) begin
      spi_bus.spi_busy <= 1'b1;
      cnt              <= lat;
      caddr            <= spi_bus.spi_addr[23:1];
      spi_bus.spi_data <= word_of(spi_bus.spi_addr[23:1]);
    end else if (spi_bus.spi_continue_read) begin
      spi_bus.spi_busy <= 1'b1;
      cnt              <= lat;
      caddr            <= caddr + 23'd1;
      spi_bus.spi_data <= word_of(caddr + 23'd1);
    end else if (spi_bus.spi_stop_read) begin
      spi_bus.spi_busy <= 1'b1;
      cnt              <= 2;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt              <= 0;
      spi_bus.spi_busy <= 1'b0;
    end
  end

  // Pulse and occupancy monitor
  int          n_start = 0, n_cont = 0, n_stop = 0;
  int          n_start_busy = 0, n_multi = 0, n_over = 0;
  logic [23:0] last_start_addr = '0;

  always @(posedge clk) begin
    if (spi_bus.spi_start_read) begin
      n_start         <= n_start + 1;
      last_start_addr <= spi_bus.spi_addr;
      if (spi_bus.spi_busy) n_start_busy <= n_start_busy + 1;
    end
    if (spi_bus.spi_continue_read) n_cont <= n_cont + 1;
    if (spi_bus.spi_stop_read)     n_stop <= n_stop + 1;
    if (int'(spi_bus.spi_start_read) + int'(spi_bus.spi_continue_read)
        + int'(spi_bus.spi_stop_read) > 1) n_multi <= n_multi + 1;
    if (int'(level) > DEPTH) n_over <= n_over + 1;
  end

  // Log of distinct spi_addr values
  logic [23:0] addr_log[$];
  logic [23:0] prev_addr = '0;

  always @(negedge clk) begin
    if (spi_bus.spi_addr !== prev_addr) addr_log.push_back(spi_bus.spi_addr);
    prev_addr <= spi_bus.spi_addr;
  end

  function automatic logic [31:0] log_at(input int i);
    if (i < addr_log.size()) return 32'(addr_log[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    for (int i = 0; i < maxc && !data_valid; i++) tick();
    check(tag, 32'(data_valid), 32'd1);
  endtask

  task automatic wait_state(input state_t s, input int maxc, input string tag);
    for (int i = 0; i < maxc && dut.state != s; i++) tick();
    check(tag, 32'(dut.state), 32'(s));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_data"}, 32'(data_out), 32'd0);
    check({tag, "_pulses"}, 32'({spi_bus.spi_start_read, spi_bus.spi_continue_read,
                                 spi_bus.spi_stop_read}), 32'd0);
    check({tag, "_addr"}, 32'(spi_bus.spi_addr), 32'd0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] exp_addr;
    int          got;
    int          s_start, s_cont, s_stop, s_sb, base;
    int          pop_pct;
    logic        r, h, p, halted;

    // Reset state
    tick();
    check_reset_outputs("reset");
    @(negedge clk); rstn = 1'b1;

    // Restart at word 0x10, first word arrives after controller latency
    @(negedge clk); restart = 1'b1; restart_addr = 23'h10;
    @(negedge clk); restart = 1'b0;
    #1;
    check("start_pulse", 32'(spi_bus.spi_start_read), 32'd1);
    check("start_addr_comb", 32'(spi_bus.spi_addr), 32'h20);
    wait_valid(20, "first_valid");
    check("first_word", 32'(data_out), 32'hA001);
    check("n_start_1", 32'(n_start), 32'd1);
    check("start_addr", 32'(last_start_addr), 32'h20);

    // Fill without popping
    wait_state(FULL, 60, "fill_full");
    check("fill_level", 32'(level), 32'd4);
    check("fill_conts", 32'(n_cont), 32'd4);
    check("fill_addr", 32'(spi_bus.spi_addr), 32'h28);
    check("fill_head", 32'(data_out), 32'hA001);

    // Single pop in FULL pushes the held word in the same cycle
    data_pop = 1'b1;
    #1;
    check("full_pop_cont", 32'(spi_bus.spi_continue_read), 32'd1);
    @(negedge clk); data_pop = 1'b0;
    #1;
    check("pop_level", 32'(level), 32'd4);
    check("pop_head", 32'(data_out), 32'(word_of(23'h11)));
    check("pop_addr", 32'(spi_bus.spi_addr), 32'h2A);
    check("pop_conts", 32'(n_cont), 32'd5);
    check("pop_state", 32'(dut.state), 32'(FETCH));

    // Continuous pop: words in address order
    exp_addr = 23'h11;
    got      = 0;
    data_pop = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (data_valid) begin
        check("stream_word", 32'(data_out), 32'(word_of(exp_addr)));
        exp_addr = exp_addr + 23'd1;
        got++;
      end
      tick();
    end
    data_pop = 1'b0;
    check("stream_rate", 32'(got >= 15), 32'd1);

    // Restart to 0x200 from FETCH with level 3
    for (int i = 0; i < 40 && !(int'(level) == 3 && dut.state == FETCH); i++) tick();
    check("pre_restart_level", 32'(level), 32'd3);
    s_start = n_start; s_stop = n_stop; s_sb = n_start_busy;
    restart = 1'b1; restart_addr = 23'h200;
    #1;
    check("restart_stop_pulse", 32'(spi_bus.spi_stop_read), 32'd1);
    @(negedge clk); restart = 1'b0;
    #1;
    check("restart_level", 32'(level), 32'd0);
    check("restart_valid", 32'(data_valid), 32'd0);
    check("restart_state", 32'(dut.state), 32'(STOPPING));
    check("restart_nstop", 32'(n_stop), 32'(s_stop + 1));
    wait_valid(40, "restart_valid2");
    check("restart_nstart", 32'(n_start), 32'(s_start + 1));
    check("restart_start_idle", 32'(n_start_busy), 32'(s_sb));
    check("restart_start_addr", 32'(last_start_addr), 32'h400);
    check("restart_word", 32'(data_out), 32'(word_of(23'h200)));

    // Address wrap
    base = addr_log.size();
    restart = 1'b1; restart_addr = 23'h7FFFFF;
    @(negedge clk); restart = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("wrap_log0", log_at(base), 32'hFFFFFE);
    check("wrap_log1", log_at(base + 1), 32'h000000);
    check("wrap_log2", log_at(base + 2), 32'h000002);
    check("wrap_head0", 32'(data_out), 32'(word_of(23'h7FFFFF)));
    data_pop = 1'b1;
    tick();
    check("wrap_head1", 32'(data_out), 32'(word_of(23'h0)));
    tick();
    check("wrap_head2", 32'(data_out), 32'(word_of(23'h1)));
    data_pop = 1'b0;

    // Halt in FULL
    wait_state(FULL, 60, "halt_full");
    s_start = n_start; s_cont = n_cont; s_stop = n_stop;
    halt = 1'b1;
    #1;
    check("halt_stop_pulse", 32'(spi_bus.spi_stop_read), 32'd1);
    @(negedge clk); halt = 1'b0;
    #1;
    check("halt_state", 32'(dut.state), 32'(IDLE));
    check("halt_level", 32'(level), 32'd0);
    check("halt_valid", 32'(data_valid), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("halt_nstop", 32'(n_stop), 32'(s_stop + 1));
    check("halt_nstart", 32'(n_start), 32'(s_start));
    check("halt_ncont", 32'(n_cont), 32'(s_cont));

    // Asynchronous reset mid-fetch
    restart = 1'b1; restart_addr = 23'h1234;
    @(negedge clk); restart = 1'b0;
    wait_valid(40, "mid_valid");
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk); rstn = 1'b1;

    // Randomized streaming with restarts and halts
    for (int it = 0; it < 4; it++) begin
      lat     = int'($urandom_range(1, 4));
      pop_pct = int'($urandom_range(30, 100));
      halted  = 1'b0;
      exp_addr = '0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        r = (c == 0) || ($urandom_range(0, 79) == 0);
        h = !r && ($urandom_range(0, 149) == 0);
        p = (int'($urandom_range(1, 100)) <= pop_pct);
        restart  = r;
        halt     = h;
        data_pop = p;
        if (r) begin
          if ($urandom_range(0, 3) == 0) restart_addr = 23'h7FFFFF - 23'($urandom_range(0, 3));
          else                           restart_addr = 23'($urandom());
        end
        #1;
        if (halted) check("rand_halt_idle", 32'(data_valid), 32'd0);
        if (!r && !h && p && data_valid) begin
          check("rand_word", 32'(data_out), 32'(word_of(exp_addr)));
          exp_addr = exp_addr + 23'd1;
        end
        if (r) begin
          exp_addr = restart_addr;
          halted   = 1'b0;
        end else if (h) begin
          halted = 1'b1;
        end
      end
      @(negedge clk);
      restart = 1'b0; halt = 1'b0; data_pop = 1'b0;
    end

    tick();
    check("one_pulse_max", 32'(n_multi), 32'd0);
    check("level_bound", 32'(n_over), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
